// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the TX FIFO handshake state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LAUNCH = 2'b01,
        S_BUSY   = 2'b10,
        S_DONE   = 2'b11
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: circular byte store with registered occupancy flags.
// Pushes while full are dropped; pops while empty are ignored.
module uart_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_W-1:0]     i_wr_data,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    assign w_push      = i_push && !r_full;
    assign w_pop       = i_pop && !r_empty;
    assign w_count_nxt = r_count + (DEPTH_LOG2 + 1)'(w_push) - (DEPTH_LOG2 + 1)'(w_pop);

    // Flags are derived from the next count so they are true registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_count <= w_count_nxt;
            r_full  <= w_count_nxt == FULL_CNT;
            r_empty <= w_count_nxt == '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue feeding a UART transmitter via write_en/rdy handshake.
// Define UART_TX_FIFO_OVF_EN to add a sticky o_ovf flag for dropped pushes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count,
    input  logic                  i_tx_rdy,
    output logic                  o_tx_write_en,
    output logic [DATA_W-1:0]     o_tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                  o_ovf
`endif
);

    tx_fifo_state_t    r_state;
    tx_fifo_state_t    w_state_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_tx_data_nxt;
    logic [DATA_W-1:0] w_head;
    logic              w_pop;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (i_wr_en),
        .i_pop     (w_pop),
        .i_wr_data (i_wr_data),
        .o_rd_data (w_head),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_count   (o_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_data <= w_tx_data_nxt;
        end
    end

    // The head entry stays in the FIFO until the transmitter reports completion.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_data_nxt = r_tx_data;
        w_pop         = 1'b0;
        o_tx_write_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!o_empty && i_tx_rdy) begin
                    w_state_nxt   = S_LAUNCH;
                    w_tx_data_nxt = w_head;
                end
            end
            S_LAUNCH: begin
                o_tx_write_en = 1'b1;
                w_state_nxt   = S_BUSY;
            end
            S_BUSY: begin
                if (!i_tx_rdy) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_tx_rdy) begin
                    w_state_nxt = S_IDLE;
                    w_pop       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_tx_data = r_tx_data;

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_ovf <= 1'b0;
        else if (i_wr_en && o_full) r_ovf <= 1'b1;
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a modelled transmitter for uart_tx_fifo.
module tb_uart_tx_fifo;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    typedef struct {
        logic [7:0]  d;
        logic [DL:0] cnt;
        logic        full;
        logic        ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          full;
    logic          empty;
    logic [DL:0]   count;
    logic          tx_we;
    logic [7:0]    tx_data;
    logic          tx_rdy;
    logic          model_rdy = 1'b1;
    logic          force_low = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf;
`endif

    int         compared = 0;
    int         mismatched = 0;
    int         pulses = 0;
    int         m_occ = 0;
    int         cnt = 0;
    bit         pop_next = 0;
    bit         chk_cnt = 0;
    logic       prev_we = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_q [$];
    vec_t       v [17];

    assign tx_rdy = model_rdy && !force_low;

    uart_tx_fifo #(.DEPTH_LOG2(DL), .DATA_W(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .i_tx_rdy      (tx_rdy),
        .o_tx_write_en (tx_we),
        .o_tx_data     (tx_data)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .o_ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model and scoreboard sink, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cnt = 0;
            model_rdy = 1'b1;
            pop_next = 0;
            chk_cnt = 0;
            prev_we = 1'b0;
            prev_data = tx_data;
        end else begin
            if (chk_cnt) begin
                check("count_after_pop", count, m_occ);
                check("empty_after_pop", empty, m_occ == 0);
                chk_cnt = 0;
            end
            if (tx_we) begin
                pulses++;
                check("we_while_rdy", tx_rdy, 1);
                check("we_consecutive", prev_we, 0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_data: pulse with data %0h but no byte expected", tx_data);
                end else check("sb_data", tx_data, exp_q.pop_front());
                cnt = 1;
            end else begin
                check("data_stable", tx_data, prev_data);
                if (cnt > 0) begin
                    cnt++;
                    if (cnt == 3) model_rdy = 1'b0;
                    if (cnt == 13) begin
                        model_rdy = 1'b1;
                        pop_next = 1;
                        cnt = 0;
                    end
                end
            end
            prev_we = tx_we;
            prev_data = tx_data;
        end
    end

    initial forever begin
        @(posedge clk);
        if (pop_next && rst_n) begin
            m_occ--;
            pop_next = 0;
            chk_cnt = 1;
        end
    end

    task automatic push_now(input logic [7:0] d);
        bit acc;
        wr_en = 1'b1;
        wr_data = d;
        acc = m_occ < DEPTH;
        @(posedge clk);
        if (acc) begin
            m_occ++;
            exp_q.push_back(d);
        end
        #1 wr_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        push_now(d);
    endtask

    task automatic drain(input string name);
        int waited = 0;
        while (waited < 3000 && !(m_occ == 0 && cnt == 0 && !pop_next)) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_drain_in_time"}, waited < 3000, 1);
        @(negedge clk);
        check({name, "_count"}, count, 0);
        check({name, "_empty"}, empty, 1);
        check({name, "_sb_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int t;
        for (int i = 0; i < 16; i++) v[i] = '{d: 8'(i + 1), cnt: 5'(i + 1), full: i == 15, ovf: 1'b0};
        v[16] = '{d: 8'hFF, cnt: 5'd16, full: 1'b1, ovf: 1'b1};

        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_we", tx_we, 0);
        check("rst_data", tx_data, 0);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;

        p0 = pulses;
        push(8'hA5);
        @(negedge clk);
        check("single_count", count, 1);
        check("single_not_empty", empty, 0);
        check("single_we_wait", tx_we, 0);
        @(negedge clk);
        check("single_we", tx_we, 1);
        check("single_data", tx_data, 8'hA5);
        drain("single");
        check("single_pulses", pulses - p0, 1);
        check("single_data_held", tx_data, 8'hA5);

        p0 = pulses;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        drain("three");
        check("three_pulses", pulses - p0, 3);

        force_low = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(v[i].d);
            @(negedge clk);
            check("fill_count", count, v[i].cnt);
            check("fill_full", full, v[i].full);
            check("fill_empty", empty, 0);
`ifdef UART_TX_FIFO_OVF_EN
            check("fill_ovf", ovf, v[i].ovf);
`endif
        end
        p0 = pulses;
        force_low = 1'b0;
        drain("fill");
        check("fill_pulses", pulses - p0, 16);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_sticky", ovf, 1);
`endif

        force_low = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        @(negedge clk);
        check("wrap_prefill", count, 5);
        force_low = 1'b0;
        for (int k = 0; k < 35; k++) begin
            t = 0;
            while (!pop_next && t < 400) begin
                #1;
                t++;
            end
            check("wrap_pop_in_time", t < 400, 1);
            if (t >= 400) break;
            push_now(8'h20 + 8'(k));
            @(negedge clk);
            check("same_edge_count", count, 5);
        end
        drain("wrap");

        p0 = pulses;
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        t = 0;
        while (cnt != 6 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", t < 200, 1);
        check("done_count", count, 4);
        rst_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_we", tx_we, 0);
        check("arst_data", tx_data, 0);
        exp_q.delete();
        m_occ = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (40) @(negedge clk);
        check("post_rst_pulses", pulses - p0, 0);
        check("post_rst_count", count, 0);
        check("post_rst_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer that sits directly upstream of the UART transmitter and feeds its data/write_en/rdy handshake.
- The host pushes bytes at any rate. The block queues them and launches one transmitter frame per byte.
- It holds each byte stable on tx_data for the whole frame, because the transmitter reads data bits serially from that bus.
- It pops a byte only after the transmitter signals completion.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
- DATA_W, 8, byte width; must match the transmitter's data bus.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host push request.
- wr_data  input  DATA_W  byte to push.
- full  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH_LOG2+1  current occupancy.
- tx_rdy  input  1  transmitter ready (high when idle).
- tx_write_en  output  1  one-cycle frame-start pulse to the transmitter.
- tx_data  output  DATA_W  byte presented to the transmitter, held for the full frame.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: count=0, empty=1, full=0, tx_write_en=0, tx_data=0, FSM=S_IDLE, read/write pointers=0. Storage contents are don't-care.
- Reset asserted mid-frame: all of the above is applied immediately; queued bytes are discarded and the transmitter sees tx_write_en=0.
- Push: accepted iff wr_en=1 and registered full=0. wr_data is written at the write pointer, and the write pointer increments (wraps modulo depth).
- Push when full: silently dropped; pointers and count are unchanged.
- full, empty and count are registered and reflect state after the current edge. count increments on push and decrements on pop. Simultaneous push and pop leaves count unchanged.
- FSM states:
  - S_IDLE: if empty=0 and tx_rdy=1, load tx_data with the head entry and go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH: tx_write_en=1 for exactly this one cycle, then go to S_BUSY.
  - S_BUSY: wait for tx_rdy=0, which is the transmitter acknowledging the start. tx_rdy=1 here is stale and ignored. On tx_rdy=0 go to S_DONE.
  - S_DONE: wait for tx_rdy=1 (frame complete). Then pop (read pointer +1 with wrap, count −1) and return to S_IDLE.
- tx_write_en is asserted only in S_LAUNCH and never for two consecutive cycles.
- tx_data is stable from S_LAUNCH entry until the pop edge; it changes only on S_IDLE→S_LAUNCH.
- Latency: a byte pushed at edge N into an empty FIFO, with tx_rdy=1, gives tx_data valid and the FSM in S_LAUNCH after edge N+1. tx_write_en is high during cycle N+1.
- Back-to-back frames: after a pop, S_IDLE relaunches on the next edge if the FIFO is non-empty and tx_rdy=1.
- Push into the head slot while a frame is in flight is impossible, because the head is not popped until frame completion.
- Simultaneous push and pop while full: the push is dropped (full is registered). The pop still occurs.
- Pointer wrap: both pointers are DEPTH_LOG2 bits and wrap naturally; occupancy is tracked by count, not by pointer compare.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- When defined: adds output port ovf (1 bit), reset 0. ovf is set sticky when wr_en=1 and full=1, and is cleared only by reset.
- When undefined: no ovf port; a dropped push leaves no trace.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - tx_fifo_state_t enum: S_IDLE=2'b00, S_LAUNCH=2'b01, S_BUSY=2'b10, S_DONE=2'b11.
- Natural sub-module uart_fifo_mem: storage array, write/read pointers, count/full/empty, push/pop inputs, head-data output.
- The top-level instantiates uart_fifo_mem plus the handshake FSM and tx_data register.

Test Plan:
- Push 8'hA5 into an empty FIFO with tx_rdy=1, and model the transmitter dropping rdy 2 cycles later and restoring it after 10 cycles. Required:
  - a single tx_write_en pulse one cycle after the push;
  - tx_data=8'hA5 constant throughout;
  - count 1→0 on the tx_rdy rise;
  - empty=1 afterwards.
- Push 3 bytes (8'h01, 8'h02, 8'h03) back-to-back. Required: exactly 3 tx_write_en pulses; tx_data sequence 01,02,03; no pulse while tx_rdy=0.
- Fill 16 entries with tx_rdy=0, then push 8'hFF. Required:
  - full=1, count=16;
  - the 17th byte is dropped;
  - with UART_TX_FIFO_OVF_EN, ovf=1 and stays 1;
  - after releasing tx_rdy, bytes 1–16 are emitted in order.
- Push and pop on the same edge at count=5. Required: count stays 5 and data order is preserved across pointer wrap (fill/drain 40 bytes total).
- Assert rst_n=0 while in S_DONE with count=4. Required: immediately count=0, empty=1, tx_write_en=0, tx_data=0, and no further pulses after release.
